// File: rtl/symbol_aligner.sv
// symbol_aligner: buffers a frame of baseband samples in a 256-entry ring and,
// on fine_done, streams NUM_SYM aligned OFDM symbols to the FFT stage.
// Ports: clk/rst (sync, active-high); input_valid, signal_real/imag in;
// fine_num/fine_done from the correlator; out_ready in; out_valid,
// out_real/imag, sym_start, sym_idx, frame_done, overflow (sticky) out.
// Build option: SYMBOL_ALIGN_CP_STRIP_EN removes the cyclic prefix.
module symbol_aligner #(
  parameter int FIXED_POINT_WIDTH = 16,
  parameter int SYNC_OFFSET       = 64,
  parameter int CP_LEN            = 16,
  parameter int FFT_LEN           = 64,
  parameter int NUM_SYM           = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         input_valid,
  input  logic [FIXED_POINT_WIDTH-1:0] signal_real,
  input  logic [FIXED_POINT_WIDTH-1:0] signal_imag,
  input  logic [7:0]                   fine_num,
  input  logic                         fine_done,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [FIXED_POINT_WIDTH-1:0] out_real,
  output logic [FIXED_POINT_WIDTH-1:0] out_imag,
  output logic                         sym_start,
  output logic [3:0]                   sym_idx,
  output logic                         frame_done,
  output logic                         overflow
);

`ifdef SYMBOL_ALIGN_CP_STRIP_EN
  localparam bit STRIP   = 1'b1;
  localparam int SYM_LEN = FFT_LEN;
`else
  localparam bit STRIP   = 1'b0;
  localparam int SYM_LEN = CP_LEN + FFT_LEN;
`endif

  localparam logic [7:0] LAST_SAMP = 8'(SYM_LEN - 1);
  localparam logic [3:0] LAST_SYM  = 4'(NUM_SYM - 1);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, WAIT_SYNC, STREAM, DONE
  } state_t;

  state_t state, state_next;

  logic [FIXED_POINT_WIDTH-1:0] ring_re [0:255];
  logic [FIXED_POINT_WIDTH-1:0] ring_im [0:255];

  logic [10:0] wr_idx;
  logic [10:0] rd_idx;
  logic [7:0]  samp_cnt;
  logic [3:0]  rd_sym;
  logic        rd_busy;
  logic        skip;
  logic        out_last;
  logic        out_final;

  logic accept;
  logic full;
  logic wr_en;
  logic rd_en;
  logic set_ovf;
  logic frame_end;

  assign accept = out_valid && out_ready;

  // Ring holds 256 unread samples: the next write would clobber rd_idx.
  assign full = (wr_idx >= rd_idx) &&
                ((wr_idx - rd_idx) >= 11'd256);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    set_ovf    = 1'b0;
    frame_end  = 1'b0;
    unique case (state)
      IDLE: begin
        if (input_valid) begin
          wr_en      = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!input_valid) begin
          state_next = IDLE;
        end else begin
          wr_en = 1'b1;
          if (fine_done) begin
            state_next = STREAM;
          end else if (wr_idx == 11'd255) begin
            set_ovf    = 1'b1;
            state_next = DONE;
          end
        end
      end
      STREAM: begin
        if (!input_valid) begin
          state_next = IDLE;
        end else if (rd_busy && full) begin
          set_ovf    = 1'b1;
          state_next = DONE;
        end else begin
          wr_en = 1'b1;
          rd_en = rd_busy && !skip &&
                  (rd_idx < wr_idx) &&
                  (!out_valid || out_ready);
          if (accept && out_final) begin
            frame_end  = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!input_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // wr_idx is always 0 in IDLE, so the first sample lands at index 0.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      ring_re[wr_idx[7:0]] <= signal_real;
      ring_im[wr_idx[7:0]] <= signal_imag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      samp_cnt   <= '0;
      rd_sym     <= '0;
      rd_busy    <= 1'b0;
      skip       <= 1'b0;
      out_valid  <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      sym_start  <= 1'b0;
      sym_idx    <= '0;
      out_last   <= 1'b0;
      out_final  <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (set_ovf) overflow <= 1'b1;
      if (state_next == IDLE) begin
        // Entering or staying idle: clear counters, drop pending output.
        wr_idx    <= '0;
        rd_idx    <= '0;
        samp_cnt  <= '0;
        rd_sym    <= '0;
        rd_busy   <= 1'b0;
        skip      <= 1'b0;
        out_valid <= 1'b0;
        sym_start <= 1'b0;
        sym_idx   <= '0;
        out_last  <= 1'b0;
        out_final <= 1'b0;
      end else begin
        if (wr_en) wr_idx <= wr_idx + 11'd1;
        if (state == CAPTURE && state_next == STREAM) begin
          rd_idx  <= {3'b000, fine_num} + 11'(SYNC_OFFSET);
          rd_busy <= 1'b1;
          skip    <= STRIP;
        end
        if (state == STREAM && skip) begin
          rd_idx <= rd_idx + 11'(CP_LEN);
          skip   <= 1'b0;
        end
        if (rd_en) begin
          out_valid <= 1'b1;
          out_real  <= ring_re[rd_idx[7:0]];
          out_imag  <= ring_im[rd_idx[7:0]];
          sym_start <= (samp_cnt == 8'd0);
          out_last  <= (samp_cnt == LAST_SAMP);
          out_final <= (samp_cnt == LAST_SAMP) &&
                       (rd_sym == LAST_SYM);
          rd_idx    <= rd_idx + 11'd1;
          if (samp_cnt == LAST_SAMP) begin
            samp_cnt <= '0;
            rd_sym   <= rd_sym + 4'd1;
            skip     <= STRIP;
            if (rd_sym == LAST_SYM) rd_busy <= 1'b0;
          end else begin
            samp_cnt <= samp_cnt + 8'd1;
          end
        end else if (accept) begin
          out_valid <= 1'b0;
          sym_start <= 1'b0;
        end
        if (accept && out_last && !out_final)
          sym_idx <= sym_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_symbol_aligner.sv
// tb_symbol_aligner: directed frames for symbol_aligner using ramp samples.
// Table of frame scenarios plus a hand-written overflow sequence.
module tb_symbol_aligner;

`ifdef SYMBOL_ALIGN_CP_STRIP_EN
  localparam int SL  = 64;
  localparam int CPO = 16;
`else
  localparam int SL  = 80;
  localparam int CPO = 0;
`endif
  localparam int STRIDE = 80;
  localparam int NSYM   = 8;

  logic        clk;
  logic        rst;
  logic        input_valid;
  logic [15:0] signal_real;
  logic [15:0] signal_imag;
  logic [7:0]  fine_num;
  logic        fine_done;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_real;
  logic [15:0] out_imag;
  logic        sym_start;
  logic [3:0]  sym_idx;
  logic        frame_done;
  logic        overflow;

  symbol_aligner dut (
    .clk         (clk),
    .rst         (rst),
    .input_valid (input_valid),
    .signal_real (signal_real),
    .signal_imag (signal_imag),
    .fine_num    (fine_num),
    .fine_done   (fine_done),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_real    (out_real),
    .out_imag    (out_imag),
    .sym_start   (sym_start),
    .sym_idx     (sym_idx),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int fnum;
    int fat;
    bit bp;
    int cut;
    bit use_rst;
    int first;
    int last;
  } vec_t;

  vec_t vecs [6];

  task automatic run_frame(input vec_t v);
    int n = 0;
    int k = 0;
    int j = 0;
    int acc = 0;
    int cyc = 0;
    int last = -1;
    int expv;
    int fd = 0;
    bit held = 0;
    bit fin = 0;
    bit ended = 0;
    bit rdy;
    logic [15:0] hr = '0;
    logic        hs = 1'b0;
    logic [15:0] er;
    logic [15:0] ei;
    while (!ended && cyc < 3000) begin
      if (held) begin
        chk("hold valid", 32'(out_valid), 32'd1);
        chk("hold real", 32'(out_real), 32'(hr));
        chk("hold sym_start", 32'(sym_start), 32'(hs));
      end
      if (frame_done || fin) begin
        chk("frame_done", 32'(frame_done), 32'(fin));
        ended = 1;
      end else begin
        // Toggling is bounded so the frame cannot overrun the ring.
        rdy = (v.bp && cyc < 300) ? cyc[0] : 1'b1;
        out_ready = rdy;
        if (out_valid && rdy) begin
          expv = v.first + k * STRIDE + j;
          er = 16'(expv);
          ei = ~er;
          chk("data real", 32'(out_real), 32'(er));
          chk("data imag", 32'(out_imag), 32'(ei));
          chk("sym_start", 32'(sym_start), 32'(j == 0));
          chk("sym_idx", 32'(sym_idx), 32'(k));
          last = expv;
          acc++;
          if (j == SL - 1) begin
            j = 0;
            k++;
          end else begin
            j++;
          end
          if (k == NSYM) fin = 1;
        end
        held = out_valid && !rdy;
        hr = out_real;
        hs = sym_start;
        if (v.cut != 0 && acc == v.cut) begin
          if (v.use_rst) begin
            rst = 1'b1;
          end else begin
            input_valid = 1'b0;
            fine_done = 1'b0;
          end
          @(negedge clk);
          chk("cut out_valid", 32'(out_valid), 32'd0);
          chk("cut frame_done", 32'(frame_done), 32'd0);
          if (v.use_rst) begin
            chk("rst sym_start", 32'(sym_start), 32'd0);
            chk("rst sym_idx", 32'(sym_idx), 32'd0);
            chk("rst out_real", 32'(out_real), 32'd0);
            chk("rst out_imag", 32'(out_imag), 32'd0);
            chk("rst overflow", 32'(overflow), 32'd0);
          end
          rst = 1'b0;
          input_valid = 1'b0;
          fine_done = 1'b0;
          repeat (5) begin
            @(negedge clk);
            if (frame_done) fd++;
          end
          chk("no frame_done after cut", 32'(fd), 32'd0);
          return;
        end
        input_valid = 1'b1;
        signal_real = 16'(n);
        signal_imag = ~16'(n);
        fine_done = (n == v.fat);
        fine_num = 8'(v.fnum);
        n++;
        @(negedge clk);
        cyc++;
      end
    end
    chk("frame ended in budget", 32'(ended), 32'd1);
    chk("symbols accepted", 32'(k), 32'(NSYM));
    chk("last sample", 32'(last), 32'(v.last));
    input_valid = 1'b0;
    fine_done = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("frame_done one cycle", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    chk("idle out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic run_overflow(input int first);
    int n = 0;
    int ovf_n = -1;
    int vhi = 0;
    int fd = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 600 && ovf_n < 0; c++) begin
      input_valid = 1'b1;
      signal_real = 16'(n);
      signal_imag = ~16'(n);
      fine_done = (n == 128);
      fine_num = 8'd5;
      if (n > 128) out_ready = 1'b0;
      n++;
      @(negedge clk);
      if (frame_done) fd++;
      if (overflow) ovf_n = n - 1;
    end
    chk("overflow write index", 32'(ovf_n), 32'(first + 257));
    chk("pending valid", 32'(out_valid), 32'd1);
    chk("pending data", 32'(out_real), 32'(first));
    out_ready = 1'b1;
    @(negedge clk);
    chk("drained valid", 32'(out_valid), 32'd0);
    repeat (4) begin
      @(negedge clk);
      if (out_valid) vhi++;
      if (frame_done) fd++;
    end
    chk("valid stays low in DONE", 32'(vhi), 32'd0);
    chk("no frame_done on overflow", 32'(fd), 32'd0);
    input_valid = 1'b0;
    fine_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("overflow sticky", 32'(overflow), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("overflow cleared by rst", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    input_valid = 1'b0;
    signal_real = '0;
    signal_imag = '0;
    fine_num = '0;
    fine_done = 1'b0;
    out_ready = 1'b1;

    vecs[0] = '{5, 128, 1'b0, 0, 1'b0, 69 + CPO, 708};
    vecs[1] = '{5, 128, 1'b1, 0, 1'b0, 69 + CPO, 708};
    vecs[2] = '{20, 60, 1'b1, 0, 1'b0, 84 + CPO, 723};
    vecs[3] = '{5, 128, 1'b0, 3 * SL + 10, 1'b0, 69 + CPO, -1};
    vecs[4] = '{0, 100, 1'b0, 0, 1'b0, 64 + CPO, 703};
    vecs[5] = '{5, 128, 1'b0, 2 * SL + 5, 1'b1, 69 + CPO, -1};

    repeat (3) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sym_start", 32'(sym_start), 32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset out_real", 32'(out_real), 32'd0);
    chk("reset out_imag", 32'(out_imag), 32'd0);
    chk("reset sym_idx", 32'(sym_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    run_overflow(69 + CPO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
